cpu_divmod_ctrl: RTL and testbench

Sequencer for the CPU's `NonRestoringDivider` instances.
- Accepts one divide/modulo command at a time from the execute stage over a valid/ready handshake.
- Waits for the divider to accept the command, pulses its enable, and waits for its result.
- Holds quotient/remainder plus destination register indices until write-back takes them.
- Handles divide-by-zero without using the divider, and supports abort on interrupt/flush.
- Each divider width gets one instance: `WIDTH=32` for `divmod32`, `WIDTH=64` for `divmod64`.

---
 rtl/cpu_divmod_ctrl_pkg.sv | 33 +++
 rtl/cpu_divmod_ctrl_if.sv | 48 ++++
 rtl/cpu_divmod_ctrl.sv | 109 ++++++++++
 tb/tb_cpu_divmod_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_divmod_ctrl_pkg.sv
// Shared types for the divide/modulo sequencer: FSM state encoding and
// command/result snapshot structs sized for the widest supported divider.
package pkg_cpu;

    localparam int DIVMOD_W_MAX     = 64;
    localparam int DIVMOD_IDX_W_MAX = 8;

    typedef enum logic [2:0] {
        StDivIdle,
        StDivIssue,
        StDivWait,
        StDivDone,
        StDivDrain
    } DivCtrlState;

    typedef struct packed {
        logic                        sgn;
        logic [DIVMOD_W_MAX-1:0]     num;
        logic [DIVMOD_W_MAX-1:0]     denom;
        logic [DIVMOD_IDX_W_MAX-1:0] quot_idx;
        logic [DIVMOD_IDX_W_MAX-1:0] rem_idx;
    } StrcInDivCtrlReq;

    typedef struct packed {
        logic                        valid;
        logic                        div_zero;
        logic [DIVMOD_W_MAX-1:0]     quot;
        logic [DIVMOD_W_MAX-1:0]     rem;
        logic [DIVMOD_IDX_W_MAX-1:0] quot_idx;
        logic [DIVMOD_IDX_W_MAX-1:0] rem_idx;
    } StrcOutDivCtrlRes;

endpackage

// File: rtl/cpu_divmod_ctrl_if.sv
// Bundle between the execute stage, the NonRestoringDivider and write-back.
// slave = controller side, master = surrounding CPU side.
interface cpu_divmod_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 4
);
    // valid/ready: a transfer happens on a rising clk edge where both are 1;
    // the valid side holds its payload stable until that edge.
    logic             req_valid;
    logic             req_ready;
    logic             req_sgn;
    logic [WIDTH-1:0] req_num;
    logic [WIDTH-1:0] req_denom;
    logic [IDX_W-1:0] req_quot_idx;
    logic [IDX_W-1:0] req_rem_idx;
    logic             abort;

    logic             div_enable;
    logic             div_unsgn_or_sgn;
    logic [WIDTH-1:0] div_num;
    logic [WIDTH-1:0] div_denom;
    logic             div_can_accept_cmd;
    logic             div_data_ready;
    logic [WIDTH-1:0] div_quot;
    logic [WIDTH-1:0] div_rem;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_quot;
    logic [WIDTH-1:0] res_rem;
    logic [IDX_W-1:0] res_quot_idx;
    logic [IDX_W-1:0] res_rem_idx;
    logic             res_div_zero;

    modport slave (
        input  req_valid, req_sgn, req_num, req_denom, req_quot_idx, req_rem_idx, abort,
        input  div_can_accept_cmd, div_data_ready, div_quot, div_rem, res_ready,
        output req_ready, div_enable, div_unsgn_or_sgn, div_num, div_denom,
        output res_valid, res_quot, res_rem, res_quot_idx, res_rem_idx, res_div_zero
    );

    modport master (
        output req_valid, req_sgn, req_num, req_denom, req_quot_idx, req_rem_idx, abort,
        output div_can_accept_cmd, div_data_ready, div_quot, div_rem, res_ready,
        input  req_ready, div_enable, div_unsgn_or_sgn, div_num, div_denom,
        input  res_valid, res_quot, res_rem, res_quot_idx, res_rem_idx, res_div_zero
    );
endinterface

// File: rtl/cpu_divmod_ctrl.sv
// Sequencer for one NonRestoringDivider: accept, issue, wait, hold result, abort/drain.
// Optional macro CPU_DIVMOD_ZERO_BYPASS_EN answers x/0 locally without the divider.
import pkg_cpu::*;

module cpu_divmod_ctrl #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    cpu_divmod_ctrl_if.slave bus,
    output DivCtrlState      dbg_state,
    output StrcInDivCtrlReq  dbg_req,
    output StrcOutDivCtrlRes dbg_res
);

    DivCtrlState state_q, state_d;
    logic        accept;
    logic        zero_denom;
    logic        result_in;

    assign accept = bus.req_valid && bus.req_ready && !bus.abort;

`ifdef CPU_DIVMOD_ZERO_BYPASS_EN
    assign zero_denom = (bus.req_denom == {WIDTH{1'b0}});
`else
    assign zero_denom = 1'b0;
`endif

    // div_enable is high exactly in the first StDivWait cycle, so it doubles
    // as the mask for a stale div_data_ready left over from an earlier command.
    assign result_in = bus.div_data_ready && !bus.div_enable;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StDivIdle:  if (accept) state_d = zero_denom ? StDivDone : StDivIssue;
            StDivIssue: begin
                if (bus.abort)                   state_d = StDivIdle;
                else if (bus.div_can_accept_cmd) state_d = StDivWait;
            end
            StDivWait: begin
                if (bus.abort)      state_d = result_in ? StDivIdle : StDivDrain;
                else if (result_in) state_d = StDivDone;
            end
            StDivDone:  if (bus.abort || bus.res_ready) state_d = StDivIdle;
            StDivDrain: if (bus.div_data_ready) state_d = StDivIdle;
            default:    state_d = StDivIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q              <= StDivIdle;
            bus.req_ready        <= 1'b0;
            bus.div_enable       <= 1'b0;
            bus.div_unsgn_or_sgn <= 1'b0;
            bus.div_num          <= WIDTH'(0);
            bus.div_denom        <= WIDTH'(0);
            bus.res_valid        <= 1'b0;
            bus.res_quot         <= WIDTH'(0);
            bus.res_rem          <= WIDTH'(0);
            bus.res_quot_idx     <= IDX_W'(0);
            bus.res_rem_idx      <= IDX_W'(0);
            bus.res_div_zero     <= 1'b0;
        end else begin
            state_q        <= state_d;
            bus.req_ready  <= (state_d == StDivIdle);
            bus.res_valid  <= (state_d == StDivDone);
            bus.div_enable <= (state_q == StDivIssue) && (state_d == StDivWait);
            if (accept) begin
                bus.div_unsgn_or_sgn <= bus.req_sgn;
                bus.div_num          <= bus.req_num;
                bus.div_denom        <= bus.req_denom;
                bus.res_quot_idx     <= bus.req_quot_idx;
                bus.res_rem_idx      <= bus.req_rem_idx;
                bus.res_div_zero     <= zero_denom;
                if (zero_denom) begin
                    bus.res_quot <= {WIDTH{1'b1}};
                    bus.res_rem  <= bus.req_num;
                end
            end
            if (state_q == StDivWait && state_d == StDivDone) begin
                bus.res_quot <= bus.div_quot;
                bus.res_rem  <= bus.div_rem;
            end
        end
    end

    assign dbg_state = state_q;

    always_comb begin
        dbg_req          = '0;
        dbg_req.sgn      = bus.div_unsgn_or_sgn;
        dbg_req.num      = DIVMOD_W_MAX'(bus.div_num);
        dbg_req.denom    = DIVMOD_W_MAX'(bus.div_denom);
        dbg_req.quot_idx = DIVMOD_IDX_W_MAX'(bus.res_quot_idx);
        dbg_req.rem_idx  = DIVMOD_IDX_W_MAX'(bus.res_rem_idx);

        dbg_res          = '0;
        dbg_res.valid    = bus.res_valid;
        dbg_res.div_zero = bus.res_div_zero;
        dbg_res.quot     = DIVMOD_W_MAX'(bus.res_quot);
        dbg_res.rem      = DIVMOD_W_MAX'(bus.res_rem);
        dbg_res.quot_idx = DIVMOD_IDX_W_MAX'(bus.res_quot_idx);
        dbg_res.rem_idx  = DIVMOD_IDX_W_MAX'(bus.res_rem_idx);
    end

endmodule

// File: tb/tb_cpu_divmod_ctrl.sv
// Directed scoreboard bench for cpu_divmod_ctrl with a behavioural divider model.
import pkg_cpu::*;

module tb_cpu_divmod_ctrl;

    localparam int PW = 73;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cpu_divmod_ctrl_if #(.WIDTH(32), .IDX_W(4)) bus ();

    DivCtrlState      dbg_state;
    StrcInDivCtrlReq  dbg_req;
    StrcOutDivCtrlRes dbg_res;

    cpu_divmod_ctrl #(.WIDTH(32), .IDX_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_req   (dbg_req),
        .dbg_res   (dbg_res)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard helpers ----------------
    logic [PW-1:0] exp_q[$];
    int en_count    = 0;
    int ready_count = 0;

    function automatic logic [PW-1:0] pack_res(logic [31:0] q, logic [31:0] r,
                                               logic [3:0] qi, logic [3:0] ri, logic dz);
        return {q, r, qi, ri, dz};
    endfunction

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // ---------------- divider model (not reset by rst, so late results can arrive) ----------------
    int          lat      = 20;
    logic        hold_off = 1'b0;
    logic        m_busy   = 1'b0;
    int          m_cnt    = 0;
    logic        m_ready  = 1'b0;
    logic [31:0] m_q      = '0;
    logic [31:0] m_r      = '0;

    assign bus.div_can_accept_cmd = !m_busy && !hold_off;
    assign bus.div_data_ready     = m_ready;
    assign bus.div_quot           = m_q;
    assign bus.div_rem            = m_r;

    always @(posedge clk) begin
        m_ready <= 1'b0;
        if (bus.div_enable) begin
            m_busy <= 1'b1;
            m_cnt  <= lat;
            if (bus.div_denom == 32'd0) begin
                m_q <= '1;
                m_r <= bus.div_num;
            end else if (bus.div_unsgn_or_sgn) begin
                m_q <= $signed(bus.div_num) / $signed(bus.div_denom);
                m_r <= $signed(bus.div_num) % $signed(bus.div_denom);
            end else begin
                m_q <= bus.div_num / bus.div_denom;
                m_r <= bus.div_num % bus.div_denom;
            end
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy  <= 1'b0;
                m_ready <= 1'b1;
            end
            m_cnt <= m_cnt - 1;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (bus.div_enable) en_count++;
        if (m_ready) ready_count++;
        if (bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result act=%0h exp=none",
                         pack_res(bus.res_quot, bus.res_rem, bus.res_quot_idx, bus.res_rem_idx, bus.res_div_zero));
            end else begin
                check("result", pack_res(bus.res_quot, bus.res_rem, bus.res_quot_idx,
                                         bus.res_rem_idx, bus.res_div_zero), exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic sgn, input logic [31:0] num, input logic [31:0] den,
                        input logic [3:0] qi, input logic [3:0] ri);
        int n = 0;
        bus.req_valid    = 1'b1;
        bus.req_sgn      = sgn;
        bus.req_num      = num;
        bus.req_denom    = den;
        bus.req_quot_idx = qi;
        bus.req_rem_idx  = ri;
        while (!bus.req_ready && n < 200) begin
            tick();
            n++;
        end
        check("send_ready_timeout", PW'(n >= 200), PW'(0));
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || dbg_state != StDivIdle) && n < 300) begin
            tick();
            n++;
        end
        check(name, PW'(exp_q.size()), PW'(0));
    endtask

    task automatic wait_state(input DivCtrlState s, input string name);
        int n = 0;
        while (dbg_state != s && n < 100) begin
            tick();
            n++;
        end
        check(name, PW'(dbg_state), PW'(s));
    endtask

    function automatic logic [PW-1:0] all_outputs();
        return PW'({bus.req_ready, bus.div_enable, bus.div_unsgn_or_sgn, bus.div_num[15:0],
                    bus.div_denom[15:0], bus.res_valid, bus.res_quot[15:0], bus.res_rem[15:0],
                    bus.res_quot_idx, bus.res_rem_idx, bus.res_div_zero});
    endfunction

    // ---------------- directed stimulus ----------------
    initial begin
        int en0;
        int rdy0;
        int bad;
        logic [PW-1:0] snap;

        bus.req_valid    = 1'b0;
        bus.req_sgn      = 1'b0;
        bus.req_num      = '0;
        bus.req_denom    = '0;
        bus.req_quot_idx = '0;
        bus.req_rem_idx  = '0;
        bus.abort        = 1'b0;
        bus.res_ready    = 1'b1;

        // reset state
        #1;
        check("reset_outputs", all_outputs(), PW'(0));
        check("reset_state", PW'(dbg_state), PW'(StDivIdle));
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("ready_after_reset", PW'(bus.req_ready), PW'(1));

        // 1. unsigned 100/7 -> 14 r 2
        en0 = en_count;
        exp_q.push_back(pack_res(32'd14, 32'd2, 4'd3, 4'd5, 1'b0));
        send(1'b0, 32'd100, 32'd7, 4'd3, 4'd5);
        wait_done("t1_done");
        check("t1_enable_pulses", PW'(en_count - en0), PW'(1));

        // 2. signed -100/7 with divider refusing for 5 cycles -> -14 r -2
        en0 = en_count;
        hold_off = 1'b1;
        exp_q.push_back(pack_res(32'hFFFF_FFF2, 32'hFFFF_FFFE, 4'd7, 4'd8, 1'b0));
        send(1'b1, 32'hFFFF_FF9C, 32'd7, 4'd7, 4'd8);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.div_enable || dbg_state != StDivIssue) bad++;
        end
        check("t2_no_enable_while_stalled", PW'(bad), PW'(0));
        hold_off = 1'b0;
        tick();
        check("t2_enable_6th_cycle", PW'(bus.div_enable), PW'(1));
        wait_done("t2_done");
        check("t2_enable_pulses", PW'(en_count - en0), PW'(1));

        // 3. 0x1234 / 0
        en0 = en_count;
`ifdef CPU_DIVMOD_ZERO_BYPASS_EN
        exp_q.push_back(pack_res(32'hFFFF_FFFF, 32'h0000_1234, 4'd1, 4'd2, 1'b1));
        send(1'b0, 32'h1234, 32'd0, 4'd1, 4'd2);
        check("t3_valid_next_cycle", PW'(bus.res_valid), PW'(1));
        wait_done("t3_done");
        check("t3_enable_pulses", PW'(en_count - en0), PW'(0));
`else
        exp_q.push_back(pack_res(32'hFFFF_FFFF, 32'h0000_1234, 4'd1, 4'd2, 1'b0));
        send(1'b0, 32'h1234, 32'd0, 4'd1, 4'd2);
        check("t3_goes_to_divider", PW'(bus.res_valid), PW'(0));
        wait_done("t3_done");
        check("t3_enable_pulses", PW'(en_count - en0), PW'(1));
`endif

        // abort while stalled in StDivIssue: back to idle, nothing issued
        en0 = en_count;
        hold_off = 1'b1;
        send(1'b0, 32'd77, 32'd7, 4'd2, 4'd3);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_issue_state", PW'(dbg_state), PW'(StDivIdle));
        hold_off = 1'b0;
        tick();
        tick();
        check("abort_issue_no_enable", PW'(en_count - en0), PW'(0));

        // 4. abort in StDivWait -> drain, then 9/3 -> 3 r 0
        send(1'b0, 32'd200, 32'd9, 4'd4, 4'd6);
        wait_state(StDivWait, "t4_reach_wait");
        tick();
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("t4_drain_state", PW'(dbg_state), PW'(StDivDrain));
        bad = 0;
        for (int i = 0; i < 100 && dbg_state != StDivIdle; i++) begin
            if (bus.req_ready || bus.res_valid) bad++;
            tick();
        end
        check("t4_drain_ready_low", PW'(bad), PW'(0));
        check("t4_drain_left_after_divider", PW'({dbg_state == StDivIdle, m_busy}), PW'(2'b10));
        exp_q.push_back(pack_res(32'd3, 32'd0, 4'd9, 4'd10, 1'b0));
        send(1'b0, 32'd9, 32'd3, 4'd9, 4'd10);
        wait_done("t4_done");

        // 5. back-pressure: 1000/33 -> 30 r 10, held 10 cycles
        bus.res_ready = 1'b0;
        exp_q.push_back(pack_res(32'd30, 32'd10, 4'd11, 4'd12, 1'b0));
        send(1'b0, 32'd1000, 32'd33, 4'd11, 4'd12);
        wait_state(StDivDone, "t5_reach_done");
        tick();
        snap = pack_res(bus.res_quot, bus.res_rem, bus.res_quot_idx, bus.res_rem_idx, bus.res_div_zero);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pack_res(bus.res_quot, bus.res_rem, bus.res_quot_idx, bus.res_rem_idx,
                         bus.res_div_zero) !== snap) bad++;
            if (bus.req_ready !== 1'b0 || bus.res_valid !== 1'b1) bad++;
        end
        check("t5_held_stable", PW'(bad), PW'(0));
        bus.res_ready = 1'b1;
        tick();
        check("t5_ready_after_consume", PW'({bus.req_ready, bus.res_valid}), PW'(2'b10));
        check("t5_queue_empty", PW'(exp_q.size()), PW'(0));

        // 6. reset during StDivWait; the late divider result must be ignored
        send(1'b1, 32'd50, 32'd5, 4'd13, 4'd14);
        wait_state(StDivWait, "t6_reach_wait");
        tick();
        rdy0 = ready_count;
        rst = 1'b1;
        #1;
        check("t6_reset_outputs", all_outputs(), PW'(0));
        check("t6_reset_state", PW'(dbg_state), PW'(StDivIdle));
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.res_valid) bad++;
        end
        check("t6_no_late_valid", PW'(bad), PW'(0));
        check("t6_late_ready_seen", PW'(ready_count - rdy0), PW'(1));
        check("t6_ready_idle", PW'(bus.req_ready), PW'(1));

        check("final_queue_empty", PW'(exp_q.size()), PW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
